// File: rtl/sram_like_responder.sv
// SRAM-like slave: in-order request acceptance, fixed-latency data_ok,
// bounded outstanding transactions, internal word-addressed RAM.
module sram_like_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LAT        = 2,
    parameter int unsigned MAX_OUT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        stall_in
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned Q_SLOTS = 1 << PTR_W;
    localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);
    localparam int unsigned LAT_W   = 3;

    typedef struct packed {
        logic             is_read;
        logic [31:0]      data;
        logic [LAT_W-1:0] cnt;
    } entry_t;

    logic [31:0]           mem [DEPTH];
    entry_t                q [Q_SLOTS];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      outstanding;
    logic [DEPTH_LOG2-1:0] idx;
    entry_t                head_c;
    logic                  accept_c;
    logic                  retire_c;
    logic                  unused_bits;

    // Size is informational and the address is not range/alignment checked
    assign unused_bits = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0]};

    assign idx      = addr[DEPTH_LOG2+1:2];
    assign head_c   = q[rd_ptr];
    assign addr_ok  = !reset && !stall_in && (outstanding < CNT_W'(MAX_OUT));
    assign accept_c = req && addr_ok;
    assign retire_c = !reset && (outstanding != '0) && (head_c.cnt == '0);
    assign data_ok  = retire_c;
    assign rdata    = (retire_c && head_c.is_read) ? head_c.data : 32'h0;

    // Queue pointers wrap modulo MAX_OUT even when it is not a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (accept_c) wr_ptr <= ptr_inc(wr_ptr);
            if (retire_c) rd_ptr <= ptr_inc(rd_ptr);
            case ({accept_c, retire_c})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Countdowns run freely; stale slots are ignored because outstanding gates retire
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(Q_SLOTS); i++) begin
            if (q[i].cnt != '0) q[i].cnt <= q[i].cnt - LAT_W'(1);
        end
        if (accept_c) begin
            q[wr_ptr] <= '{is_read: !wr,
                           data:    wr ? 32'h0 : mem[idx],
                           cnt:     LAT_W'(LAT - 1)};
        end
    end

    // RAM is never reset; reads above sample it before this edge's write lands
    always_ff @(posedge clk) begin
        if (accept_c && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder with a due-cycle scoreboard and RAM model.
module tb_sram_like_responder;

    logic        clk = 1'b0;
    logic        reset, req, wr, stall_in;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;

    logic        aok0, aok1, aok2, dok0, dok1, dok2;
    logic [31:0] rd0, rd1, rd2;
    logic        obs_aok, obs_dok;
    logic [31:0] obs_rd;

    typedef struct {
        int          due;
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [int];
    int          sel, lat, max_out;
    int          cyc, n_vec, n_fail;

    always #5 clk = ~clk;

    sram_like_responder #(.DEPTH_LOG2(10), .LAT(2), .MAX_OUT(2)) u_a (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(aok0), .data_ok(dok0), .rdata(rd0),
        .stall_in(stall_in));

    sram_like_responder #(.DEPTH_LOG2(10), .LAT(4), .MAX_OUT(2)) u_b (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(aok1), .data_ok(dok1), .rdata(rd1),
        .stall_in(stall_in));

    sram_like_responder #(.DEPTH_LOG2(10), .LAT(1), .MAX_OUT(1)) u_c (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(aok2), .data_ok(dok2), .rdata(rd2),
        .stall_in(stall_in));

    always_comb begin
        obs_aok = aok0;
        obs_dok = dok0;
        obs_rd  = rd0;
        case (sel)
            1: begin obs_aok = aok1; obs_dok = dok1; obs_rd = rd1; end
            2: begin obs_aok = aok2; obs_dok = dok2; obs_rd = rd2; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, sel, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive after negedge, check mid-cycle, update model for the edge
    task automatic tick(input logic r, input logic q, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d, input logic st,
                        output logic acc);
        logic        exp_dok, exp_aok;
        logic [31:0] exp_rd, word;
        int          widx;
        reset = r; req = q; wr = w; wstrb = s; addr = a; wdata = d; stall_in = st;
        size  = 2'd2;
        #1;
        exp_dok = !r && (sb.size() > 0) && (sb[0].due == cyc);
        exp_rd  = 32'h0;
        if (exp_dok && sb[0].is_read) exp_rd = sb[0].data;
        exp_aok = !r && !st && (sb.size() < max_out);
        chk("addr_ok", 32'(obs_aok), 32'(exp_aok));
        chk("data_ok", 32'(obs_dok), 32'(exp_dok));
        chk("rdata", obs_rd, exp_rd);
        if (exp_dok) void'(sb.pop_front());
        acc = q && exp_aok;
        if (r) begin
            sb.delete();
        end else if (acc) begin
            widx = int'(a[11:2]);
            word = mem_m.exists(widx) ? mem_m[widx] : 32'h0;
            if (w) begin
                for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
                mem_m[widx] = word;
                sb.push_back('{cyc + lat, 1'b0, 32'h0});
            end else begin
                sb.push_back('{cyc + lat, 1'b1, word});
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // Hold a request until the model says it is taken, bounded
    task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d);
        logic acc;
        int   n;
        n = 0;
        do begin
            tick(1'b0, 1'b1, w, s, a, d, 1'b0, acc);
            n++;
        end while (!acc && n < 8);
        chk("accept_bound", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acc);
    endtask

    task automatic start(input int which, input int l, input int m);
        logic acc;
        sel = which; lat = l; max_out = m;
        sb.delete();
        mem_m.delete();
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        cyc = 0; n_vec = 0; n_fail = 0;

        // LAT=2, MAX_OUT=2: basic, strobes, stall, reset mid-flight
        start(0, 2, 2);
        issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 4'hF, 32'h10, 32'h0);
        idle(3);
        issue(1'b1, 4'hF, 32'h20, 32'h11223344);
        issue(1'b1, 4'b0100, 32'h20, 32'h00AA0000);
        issue(1'b0, 4'hF, 32'h20, 32'h0);
        issue(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF);
        issue(1'b0, 4'hF, 32'h20, 32'h0);
        idle(3);
        issue(1'b0, 4'hF, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, acc);
        idle(3);
        issue(1'b1, 4'hF, 32'h80, 32'hCAFEF00D);
        idle(3);
        issue(1'b0, 4'hF, 32'h10, 32'h0);
        issue(1'b0, 4'hF, 32'h20, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, acc);
        idle(5);
        issue(1'b0, 4'hF, 32'h80, 32'h0);
        idle(3);

        // LAT=4, MAX_OUT=2: outstanding limit with req held high
        start(1, 4, 2);
        issue(1'b1, 4'hF, 32'h30, 32'h0BADC0DE);
        idle(5);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b0, acc);
        idle(6);

        // LAT=1, MAX_OUT=1: alternating write/read ordering
        start(2, 1, 1);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 4'hF, 32'h40, 32'(5 + i));
            issue(1'b0, 4'hF, 32'h40, 32'h0);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
